// File: rtl/uart_add_sequencer.sv
// uart_add_sequencer
//   Collects two little-endian operands from a UART RX byte stream, holds them
//   on the carry-select adder for ADD_WAIT cycles, captures {carry, sum} and
//   streams the W+1 bit result back out as OP_BYTES+1 bytes (LSB first, then
//   the carry byte).
//
// Handshakes:
//   rx side : rx_valid_i is a one-cycle strobe; there is no backpressure.
//   tx side : a byte transfers on any cycle where tx_valid_o & tx_ready_i.
//             While tx_valid_o=1 and tx_ready_i=0, tx_data_o is held.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   rx_data_i, rx_valid_i   received byte and its strobe
//   tx_data_o, tx_valid_o   byte to transmit and its valid
//   tx_ready_i              transmitter accepts the byte
//   add_a_o, add_b_o        registered adder operands
//   add_cin_o               adder carry-in, tied 0
//   add_sum_i, add_cout_i   adder result
//   busy_o                  high unless idle waiting for the first byte of A
//   rx_drop_o               pulse: an rx byte was discarded in ADD/TX
//   timeout_o               pulse: a partial frame was abandoned
//   dbg_state               current FSM state (RX_A=0, RX_B=1, ADD=2, TX=3)
module uart_add_sequencer #(
    parameter int OP_BYTES   = 8,
    parameter int ADD_WAIT   = 2,
    parameter int RX_TIMEOUT = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              rx_data_i,
    input  logic                    rx_valid_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic [8*OP_BYTES-1:0]   add_a_o,
    output logic [8*OP_BYTES-1:0]   add_b_o,
    output logic                    add_cin_o,
    input  logic [8*OP_BYTES-1:0]   add_sum_i,
    input  logic                    add_cout_i,
    output logic                    busy_o,
    output logic                    rx_drop_o,
    output logic                    timeout_o,
    output logic [1:0]              dbg_state
);

    localparam int W  = 8 * OP_BYTES;
    localparam int CW = $clog2(OP_BYTES + 1);
    localparam int WW = $clog2(ADD_WAIT + 1);
    localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam int TLIM = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;

    localparam logic [CW-1:0] CNT_LAST = CW'(OP_BYTES - 1);
    localparam logic [CW-1:0] CNT_CARRY = CW'(OP_BYTES);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(ADD_WAIT);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TLIM);
    localparam bit            TIMEOUT_EN = (RX_TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_RX_A = 2'd0,
        S_RX_B = 2'd1,
        S_ADD  = 2'd2,
        S_TX   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [WW-1:0] wait_q;
    logic [TW-1:0] idle_q;
    logic [W:0]    res_q;
    logic          tx_valid_q;
    logic          rx_drop_q;
    logic          timeout_q;

    logic rx_take;
    logic byte_last;
    logic add_done;
    logic tx_accept;
    logic tx_last;
    logic idle_run;
    logic expire;

    // ---------------------------------------------------------------
    // Next-state and control strobes
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rx_take   = 1'b0;
        byte_last = (cnt_q == CNT_LAST);
        add_done  = 1'b0;
        tx_accept = 1'b0;
        tx_last   = (cnt_q == CNT_CARRY);
        idle_run  = 1'b0;
        expire    = 1'b0;

        case (state_q)
            S_RX_A: begin
                // No timeout before the first byte of A.
                idle_run = (cnt_q != '0);
                rx_take  = rx_valid_i;
                if (rx_valid_i && byte_last) state_d = S_RX_B;
            end
            S_RX_B: begin
                idle_run = 1'b1;
                rx_take  = rx_valid_i;
                if (rx_valid_i && byte_last) state_d = S_ADD;
            end
            S_ADD: begin
                // Sample in the cycle the wait counter runs out.
                add_done = (wait_q == WW'(1));
                if (add_done) state_d = S_TX;
            end
            S_TX: begin
                tx_accept = tx_valid_q & tx_ready_i;
                if (tx_accept && tx_last) state_d = S_RX_A;
            end
            default: state_d = S_RX_A;
        endcase

        // An arriving byte beats an expiring idle counter.
        if (TIMEOUT_EN && idle_run && !rx_valid_i && (idle_q == IDLE_LAST)) begin
            expire  = 1'b1;
            state_d = S_RX_A;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_RX_A;
        else         state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            wait_q     <= '0;
            idle_q     <= '0;
            res_q      <= '0;
            tx_valid_q <= 1'b0;
            rx_drop_q  <= 1'b0;
            timeout_q  <= 1'b0;
            add_a_o    <= '0;
            add_b_o    <= '0;
        end else begin
            rx_drop_q <= rx_valid_i && ((state_q == S_ADD) || (state_q == S_TX));
            timeout_q <= expire;

            if (!TIMEOUT_EN || !idle_run || rx_valid_i || expire) idle_q <= '0;
            else                                                  idle_q <= idle_q + TW'(1);

            if (expire)         cnt_q <= '0;
            else if (rx_take)   cnt_q <= byte_last ? '0 : cnt_q + CW'(1);
            else if (add_done)  cnt_q <= '0;
            else if (tx_accept) cnt_q <= tx_last ? '0 : cnt_q + CW'(1);

            for (int i = 0; i < OP_BYTES; i++) begin
                if (rx_take && (cnt_q == CW'(i))) begin
                    if (state_q == S_RX_A) add_a_o[i*8 +: 8] <= rx_data_i;
                    else                   add_b_o[i*8 +: 8] <= rx_data_i;
                end
            end

            if (rx_take && (state_q == S_RX_B) && byte_last) wait_q <= WAIT_LOAD;
            else if (state_q == S_ADD)                        wait_q <= wait_q - WW'(1);

            // Result is a shift register; tx_data_o is always its low byte,
            // so the byte stays put while the transmitter stalls.
            if (add_done)       res_q <= {add_cout_i, add_sum_i};
            else if (tx_accept) res_q <= res_q >> 8;

            if (state_q == S_TX) begin
                if (!tx_valid_q)              tx_valid_q <= 1'b1;
                else if (tx_accept && tx_last) tx_valid_q <= 1'b0;
            end
        end
    end

    assign tx_data_o  = res_q[7:0];
    assign tx_valid_o = tx_valid_q;
    assign add_cin_o  = 1'b0;
    assign busy_o     = !((state_q == S_RX_A) && (cnt_q == '0));
    assign rx_drop_o  = rx_drop_q;
    assign timeout_o  = timeout_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_add_sequencer.sv
// Bench for uart_add_sequencer: table of known frames, hand-written corner
// sequences (stalls, dropped bytes, timeout, reset during TX) and random
// frames checked against a plain-arithmetic reference model.
module tb_uart_add_sequencer;

    localparam int OP_BYTES = 8;
    localparam int W        = 8 * OP_BYTES;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]   rx_data = '0;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         busy, rx_drop, timeout;
    logic [1:0]   dbg_state;

    // The adder the sequencer drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    uart_add_sequencer #(
        .OP_BYTES(OP_BYTES), .ADD_WAIT(2), .RX_TIMEOUT(100)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_sum_i(add_sum), .add_cout_i(add_cout),
        .busy_o(busy), .rx_drop_o(rx_drop), .timeout_o(timeout),
        .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int tx_seen = 0;
    int drop_cnt = 0;
    int tmo_cnt = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle every 3 cycles, 2: random

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // ---------------- tx_ready driver ----------------
    int ready_ph = 0;
    always @(negedge clk) begin
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: begin
                ready_ph = (ready_ph + 1) % 6;
                tx_ready = (ready_ph < 3);
            end
            default: tx_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("tx_hold", {tx_valid, tx_data}, {1'b1, prev_data});
            if (rx_drop) drop_cnt++;
            if (timeout) tmo_cnt++;
            if (tx_valid && tx_ready) begin
                tx_seen++;
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", {1'b1, tx_data}, 9'h0);
                end else begin
                    check("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_operands(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_max);
        logic [W-1:0] va, vb;
        va = a;
        vb = b;
        for (int i = 0; i < OP_BYTES; i++) send_byte(va[i*8 +: 8], gap_max);
        for (int i = 0; i < OP_BYTES; i++) send_byte(vb[i*8 +: 8], gap_max);
    endtask

    // Reference model: W+1 bit sum, bytes LSB first, carry last.
    task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]  s;
        logic [71:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = {7'b0, s};
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(r[i*8 +: 8]);
    endtask

    task automatic wait_tx_done(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx_valid(input int budget);
        int n;
        n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("tx_valid_rise", tx_valid, 1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tx_valid"}, tx_valid, 1'b0);
        check({name, "_tx_data"}, tx_data, 8'h00);
        check({name, "_add_a"}, add_a, '0);
        check({name, "_add_b"}, add_b, '0);
        check({name, "_add_cin"}, add_cin, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_rx_drop"}, rx_drop, 1'b0);
        check({name, "_timeout"}, timeout, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [71:0]  tx;   // expected TX bytes, byte i = tx[8i+:8]
    } vec_t;

    vec_t tbl[6];

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] ra, rb;
        int base, d0, t0;

        tbl[0] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 72'h00_0000_0000_0000_0003};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 72'h01_FFFF_FFFF_FFFF_FFFE};
        tbl[2] = '{64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 72'h00_0000_0000_0000_0030};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 72'h01_0000_0000_0000_0000};
        tbl[4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 72'h00_1234_5678_9ABC_DF00};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 72'h01_0000_0000_0000_0000};

        repeat (3) @(negedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Busy rises with the first byte of A.
        send_byte(8'h01, 0);
        check("busy_after_first", busy, 1'b1);
        for (int i = 1; i < OP_BYTES; i++) send_byte(8'h00, 0);
        for (int i = 0; i < OP_BYTES; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0);
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[0].tx[i*8 +: 8]);
        check("t1_add_a", add_a, tbl[0].a);
        check("t1_add_b", add_b, tbl[0].b);
        wait_tx_done("t1_done", 200);
        check("t1_idle_busy", busy, 1'b0);

        // Table of known frames with the transmitter always ready.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[k].tx[i*8 +: 8]);
            send_operands(tbl[k].a, tbl[k].b, 1);
            wait_tx_done("tbl_done", 200);
        end

        // T3: transmitter stalls 3 cycles out of every 6.
        ready_mode = 1;
        base = tx_seen;
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[0].tx[i*8 +: 8]);
        send_operands(tbl[0].a, tbl[0].b, 0);
        wait_tx_done("t3_done", 300);
        check("t3_byte_count", tx_seen - base, OP_BYTES + 1);

        // T4: five bytes arrive during TX and are dropped.
        d0 = drop_cnt;
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[1].tx[i*8 +: 8]);
        send_operands(tbl[1].a, tbl[1].b, 0);
        wait_tx_valid(50);
        for (int i = 0; i < 5; i++) send_byte(8'hA5, 0);
        wait_tx_done("t4_done", 300);
        check("t4_drops", drop_cnt - d0, 5);
        check("t4_a_kept", add_a, tbl[1].a);
        ready_mode = 0;
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[4].tx[i*8 +: 8]);
        send_operands(tbl[4].a, tbl[4].b, 0);
        wait_tx_done("t4_next", 200);

        // T5: partial frame abandoned after 100 idle cycles.
        t0 = tmo_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'h77, 0);
        repeat (90) @(negedge clk);
        check("t5_no_early_timeout", tmo_cnt - t0, 0);
        check("t5_busy_while_partial", busy, 1'b1);
        repeat (20) @(negedge clk);
        check("t5_timeout_pulse", tmo_cnt - t0, 1);
        check("t5_busy_after", busy, 1'b0);
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[2].tx[i*8 +: 8]);
        send_operands(tbl[2].a, tbl[2].b, 0);
        wait_tx_done("t5_frame", 200);

        // T6: reset right after the 4th TX byte transfers.
        base = tx_seen;
        model_push(tbl[4].a, tbl[4].b);
        send_operands(tbl[4].a, tbl[4].b, 0);
        t0 = 0;
        while ((tx_seen - base) < 4 && t0 < 200) begin
            @(negedge clk);
            #2;
            t0++;
        end
        check("t6_reached_4", tx_seen - base, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= OP_BYTES; i++) exp_q.push_back(tbl[1].tx[i*8 +: 8]);
        send_operands(tbl[1].a, tbl[1].b, 0);
        wait_tx_done("t6_frame", 200);

        // Random frames against the reference model.
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (k % 5 == 0) ra = '1;
            if (k % 7 == 0) rb = ~ra;
            model_push(ra, rb);
            send_operands(ra, rb, 3);
            check("rand_add_a", add_a, ra);
            check("rand_add_b", add_b, rb);
            wait_tx_done("rand_done", 400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
